// File: rtl/cci_pkg.sv
// Shared types and helpers for the CCI (16-bit index I2C) register target.
package cci_pkg;

  localparam int unsigned IDX_W     = 16;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  localparam logic CCI_ACK  = 1'b0;
  localparam logic CCI_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_IDX_HI,
    ST_IDX_HI_ACK,
    ST_IDX_LO,
    ST_IDX_LO_ACK,
    ST_WR,
    ST_WR_ACK,
    ST_RD,
    ST_RD_ACK,
    ST_IGNORE
  } cci_state_t;

  // 7-bit bus address from the 8-bit write-address form.
  function automatic logic [6:0] cci_dev_addr7(input logic [7:0] addr8);
    return 7'(addr8 >> 1);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for one I2C line with rise/fall detection on the
// synchronized value. Lines idle high, so all flops reset to 1.
module i2c_line_sync (
  input  logic clk_in,
  input  logic reset,
  input  logic i_line,
  output logic o_level,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level  = r_sync;
  assign o_rise_c = r_sync & ~r_prev;
  assign o_fall_c = ~r_sync & r_prev;

endmodule

// File: rtl/cci_target.sv
// CCI target: matches the device address, latches a 16-bit register index and
// performs auto-incrementing writes/reads over a simple register port.
module cci_target #(
  parameter logic [7:0]  ADDRESS        = 8'h20,
  parameter int unsigned INPUT_CLK_RATE = 48000000
) (
  input  logic        clk_in,
  input  logic        reset,
  inout  wire         scl,
  inout  wire         sda,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);
  import cci_pkg::*;

  // Sampling relies on at least 20 clk_in cycles per SCL period at 100 kHz.
  if (INPUT_CLK_RATE < 32'd2_000_000) begin : g_rate_chk
    $error("cci_target: INPUT_CLK_RATE too low for CCI sampling");
  end

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;

  i2c_line_sync u_scl_sync (
    .clk_in   (clk_in),
    .reset    (reset),
    .i_line   (scl),
    .o_level  (w_scl_lvl),
    .o_rise_c (w_scl_rise),
    .o_fall_c (w_scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk_in   (clk_in),
    .reset    (reset),
    .i_line   (sda),
    .o_level  (w_sda_lvl),
    .o_rise_c (w_sda_rise),
    .o_fall_c (w_sda_fall)
  );

  cci_state_t             r_state,   w_state_nxt;
  logic [BIT_CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic [BYTE_W-1:0]      r_shift,   w_shift_nxt;
  logic [BYTE_W-1:0]      r_idx_hi,  w_idx_hi_nxt;
  logic                   r_rw,      w_rw_nxt;
  logic                   r_ack_drv, w_ack_drv_nxt;
  logic                   r_fall_d,  w_fall_d_nxt;
  logic                   r_sda_oe,  w_sda_oe_nxt;
  logic [IDX_W-1:0]       r_addr,    w_addr_nxt;
  logic [BYTE_W-1:0]      r_wdata,   w_wdata_nxt;
  logic                   r_we,      w_we_nxt;
  logic                   r_re,      w_re_nxt;
  logic                   r_busy,    w_busy_nxt;

  logic                   w_start;
  logic                   w_stop;
  logic                   w_last_bit;
  logic [BYTE_W-1:0]      w_byte;

  assign w_start    = w_sda_fall & w_scl_lvl;
  assign w_stop     = w_sda_rise & w_scl_lvl;
  assign w_last_bit = (r_bit_cnt == BIT_CNT_W'(BYTE_W - 1));
  assign w_byte     = {r_shift[BYTE_W-2:0], w_sda_lvl};

  // State register and all registered outputs.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_idx_hi  <= '0;
      r_rw      <= 1'b0;
      r_ack_drv <= 1'b0;
      r_fall_d  <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_idx_hi  <= w_idx_hi_nxt;
      r_rw      <= w_rw_nxt;
      r_ack_drv <= w_ack_drv_nxt;
      r_fall_d  <= w_fall_d_nxt;
      r_sda_oe  <= w_sda_oe_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_we      <= w_we_nxt;
      r_re      <= w_re_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // Next-state and output logic; START/STOP take priority over SCL edges.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_idx_hi_nxt  = r_idx_hi;
    w_rw_nxt      = r_rw;
    w_ack_drv_nxt = r_ack_drv;
    w_fall_d_nxt  = w_scl_fall;
    w_sda_oe_nxt  = r_sda_oe;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_we_nxt      = 1'b0;
    w_re_nxt      = 1'b0;
    w_busy_nxt    = r_busy;

    // Post-strobe bookkeeping: advance after a write, latch+advance after a read.
    if (r_we) begin
      w_addr_nxt = r_addr + 16'd1;
    end
    if (r_re) begin
      w_shift_nxt = reg_rdata;
      w_addr_nxt  = r_addr + 16'd1;
    end

    if (w_start) begin
      w_state_nxt   = ST_DEV;
      w_bit_cnt_nxt = '0;
      w_sda_oe_nxt  = 1'b0;
      w_ack_drv_nxt = 1'b0;
      w_fall_d_nxt  = 1'b0;
    end else if (w_stop) begin
      w_state_nxt   = ST_IDLE;
      w_sda_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
      w_ack_drv_nxt = 1'b0;
      w_fall_d_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        ST_DEV: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (w_last_bit) begin
              if (w_byte[7:1] == cci_dev_addr7(ADDRESS)) begin
                w_state_nxt = ST_DEV_ACK;
                w_busy_nxt  = 1'b1;
                w_rw_nxt    = w_byte[0];
              end else begin
                w_state_nxt = ST_IGNORE;
                w_busy_nxt  = 1'b0;
              end
            end
          end
        end
        ST_IDX_HI, ST_IDX_LO, ST_WR: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (w_last_bit) begin
              if (r_state == ST_IDX_HI) begin
                w_idx_hi_nxt = w_byte;
                w_state_nxt  = ST_IDX_HI_ACK;
              end else if (r_state == ST_IDX_LO) begin
                w_addr_nxt  = {r_idx_hi, w_byte};
                w_state_nxt = ST_IDX_LO_ACK;
              end else begin
                w_wdata_nxt = w_byte;
                w_we_nxt    = 1'b1;
                w_state_nxt = ST_WR_ACK;
              end
            end
          end
        end
        ST_DEV_ACK, ST_IDX_HI_ACK, ST_IDX_LO_ACK, ST_WR_ACK: begin
          if (r_state == ST_DEV_ACK && r_rw && w_scl_rise) begin
            w_re_nxt = 1'b1;
          end
          // First delayed fall pulls SDA for the ACK, the second ends the ACK bit.
          if (r_fall_d) begin
            if (!r_ack_drv) begin
              w_sda_oe_nxt  = ~CCI_ACK;
              w_ack_drv_nxt = 1'b1;
            end else begin
              w_ack_drv_nxt = 1'b0;
              w_bit_cnt_nxt = '0;
              w_sda_oe_nxt  = 1'b0;
              unique case (r_state)
                ST_DEV_ACK: begin
                  if (r_rw) begin
                    w_state_nxt  = ST_RD;
                    w_sda_oe_nxt = ~r_shift[7];
                  end else begin
                    w_state_nxt = ST_IDX_HI;
                  end
                end
                ST_IDX_HI_ACK: w_state_nxt = ST_IDX_LO;
                default:       w_state_nxt = ST_WR;
              endcase
            end
          end
        end
        ST_RD: begin
          if (r_fall_d) begin
            w_sda_oe_nxt = ~r_shift[3'd7 - r_bit_cnt];
          end
          if (w_scl_rise) begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (w_last_bit) begin
              w_state_nxt = ST_RD_ACK;
            end
          end
        end
        ST_RD_ACK: begin
          if (r_fall_d) begin
            w_sda_oe_nxt = 1'b0;
          end
          if (w_scl_rise) begin
            if (w_sda_lvl == CCI_NACK) begin
              w_state_nxt = ST_IGNORE;
            end else begin
              w_state_nxt   = ST_RD;
              w_bit_cnt_nxt = '0;
              w_re_nxt      = 1'b1;
            end
          end
        end
        default: begin
          w_sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  assign sda       = r_sda_oe ? 1'b0 : 1'bz;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_we    = r_we;
  assign reg_re    = r_re;
  assign busy      = r_busy;

endmodule

// File: tb/tb_cci_target.sv
// Randomized bench for cci_target: bit-banged CCI master, register-file
// responder and a transaction-level index/memory reference model.
module tb_cci_target;

  localparam int unsigned HALF = 12;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        m_scl;
  logic        m_sda_low;
  wire         scl;
  wire         sda;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [7:0]  reg_rdata;
  logic        busy;

  assign scl = m_scl;
  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk_in = ~clk_in;

  cci_target #(.ADDRESS(8'h20), .INPUT_CLK_RATE(100000000)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .scl       (scl),
    .sda       (sda),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  typedef struct packed { logic [15:0] addr; logic [7:0] data; } wr_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  regs    [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] m_idx;
  wr_t         q_wr[$];
  logic [15:0] q_re[$];
  logic [7:0]  wbuf[$];
  int unsigned dut_low_cnt = 0;
  int unsigned strobe_clash = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Register-file responder and bus observer.
  always @(negedge clk_in) begin
    if (reg_we) begin
      q_wr.push_back({reg_addr, reg_wdata});
      regs[reg_addr] = reg_wdata;
    end
    if (reg_re) begin
      q_re.push_back(reg_addr);
      reg_rdata = regs[reg_addr];
    end
    if (reg_we && reg_re) strobe_clash++;
    if (!m_sda_low && sda === 1'b0) dut_low_cnt++;
  end

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(posedge clk_in);
  endtask

  task automatic bus_start();
    if (m_scl == 1'b0) begin
      wait_clk(4);
      m_sda_low = 1'b0;
      wait_clk(HALF - 4);
      m_scl = 1'b1;
      wait_clk(HALF);
    end
    m_sda_low = 1'b1;
    wait_clk(HALF);
    m_scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(4);
    m_sda_low = 1'b1;
    wait_clk(HALF - 4);
    m_scl = 1'b1;
    wait_clk(HALF);
    m_sda_low = 1'b0;
    wait_clk(HALF);
  endtask

  // One SCL clock: drive b (1 = release), sample SDA mid-high. SCL low on entry/exit.
  task automatic clk_bit(input logic b, output logic smp);
    wait_clk(4);
    m_sda_low = ~b;
    wait_clk(HALF - 4);
    m_scl = 1'b1;
    wait_clk(HALF / 2);
    smp = (sda === 1'b0) ? 1'b0 : 1'b1;
    wait_clk(HALF / 2);
    m_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(~m_ack, s);
  endtask

  // Write transaction: set index, then write every byte in wbuf.
  task automatic txn_write(input logic [15:0] idx);
    logic a;
    q_wr.delete();
    bus_start();
    write_byte(8'h20, a);      check("wr_dev_ack", 32'(a), 32'd0);
    write_byte(idx[15:8], a);  check("wr_idx_hi_ack", 32'(a), 32'd0);
    write_byte(idx[7:0], a);   check("wr_idx_lo_ack", 32'(a), 32'd0);
    foreach (wbuf[k]) begin
      write_byte(wbuf[k], a);
      check("wr_data_ack", 32'(a), 32'd0);
      ref_mem[16'(idx + 16'(k))] = wbuf[k];
    end
    check("busy_in_wr", 32'(busy), 32'd1);
    bus_stop();
    wait_clk(4);
    check("wr_count", q_wr.size(), wbuf.size());
    foreach (wbuf[k]) begin
      if (k < q_wr.size()) begin
        check("wr_addr", 32'(q_wr[k].addr), 32'(16'(idx + 16'(k))));
        check("wr_data", 32'(q_wr[k].data), 32'(wbuf[k]));
      end
    end
    m_idx = 16'(idx + 16'(wbuf.size()));
    check("idx_after_wr", 32'(reg_addr), 32'(m_idx));
    check("busy_after_stop", 32'(busy), 32'd0);
  endtask

  // Read transaction of n bytes, optionally preceded by an index write + repeated START.
  task automatic txn_read(input logic set_idx, input logic [15:0] idx, input int unsigned n);
    logic        a;
    logic [7:0]  d;
    logic [15:0] base;
    int unsigned low0;
    q_re.delete();
    bus_start();
    if (set_idx) begin
      write_byte(8'h20, a);      check("rd_set_dev_ack", 32'(a), 32'd0);
      write_byte(idx[15:8], a);  check("rd_set_hi_ack", 32'(a), 32'd0);
      write_byte(idx[7:0], a);   check("rd_set_lo_ack", 32'(a), 32'd0);
      bus_start();
      base = idx;
    end else begin
      base = m_idx;
    end
    write_byte(8'h21, a);        check("rd_dev_ack", 32'(a), 32'd0);
    for (int unsigned k = 0; k < n; k++) begin
      read_byte(k != n - 1, d);
      check("rd_data", 32'(d), 32'(ref_mem[16'(base + 16'(k))]));
    end
    low0 = dut_low_cnt;
    read_byte(1'b0, d);
    check("rd_quiet_after_nack", dut_low_cnt - low0, 32'd0);
    check("rd_busy", 32'(busy), 32'd1);
    bus_stop();
    wait_clk(4);
    check("re_count", q_re.size(), n);
    foreach (q_re[k]) begin
      if (k < n) check("re_addr", 32'(q_re[k]), 32'(16'(base + 16'(k))));
    end
    m_idx = 16'(base + 16'(n));
    check("idx_after_rd", 32'(reg_addr), 32'(m_idx));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        a;
    logic        s;
    logic        seen;
    int unsigned low0;

    reset     = 1'b1;
    m_scl     = 1'b1;
    m_sda_low = 1'b0;
    reg_rdata = 8'h00;
    for (int i = 0; i < 65536; i++) begin
      regs[i]    = 8'($urandom);
      ref_mem[i] = regs[i];
    end
    m_idx = 16'h0000;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(5);
    #1;
    check("rst_addr", 32'(reg_addr), 32'd0);
    check("rst_wdata", 32'(reg_wdata), 32'd0);
    check("rst_we", 32'(reg_we), 32'd0);
    check("rst_re", 32'(reg_re), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sda", 32'(sda === 1'b1), 32'd1);

    // Write burst at 0x0100.
    wbuf = '{8'hAA, 8'h55};
    txn_write(16'h0100);

    // Combined read from 0x0000 returning 0x02, 0x19.
    regs[0] = 8'h02; ref_mem[0] = 8'h02;
    regs[1] = 8'h19; ref_mem[1] = 8'h19;
    txn_read(1'b1, 16'h0000, 2);

    // Address mismatch.
    q_wr.delete(); q_re.delete();
    low0 = dut_low_cnt;
    bus_start();
    write_byte(8'h30, a);  check("mis_nack", 32'(a), 32'd1);
    write_byte(8'h00, a);  check("mis_ignored", 32'(a), 32'd1);
    check("mis_busy", 32'(busy), 32'd0);
    bus_stop();
    check("mis_no_drive", dut_low_cnt - low0, 32'd0);
    check("mis_no_strobe", q_wr.size() + q_re.size(), 32'd0);

    // STOP after 5 bits of the index HI byte keeps the index.
    wbuf = '{};
    txn_write(16'h4321);
    bus_start();
    write_byte(8'h20, a);
    for (int i = 0; i < 5; i++) clk_bit(1'(i & 1), s);
    bus_stop();
    wait_clk(4);
    check("abort_idx", 32'(reg_addr), 32'(m_idx));
    check("abort_busy", 32'(busy), 32'd0);

    // Repeated START mid data byte: only the complete byte is written.
    q_wr.delete();
    bus_start();
    write_byte(8'h20, a);
    write_byte(8'h12, a);
    write_byte(8'h34, a);
    write_byte(8'h5A, a);
    for (int i = 0; i < 4; i++) clk_bit(1'b0, s);
    bus_start();
    bus_stop();
    wait_clk(4);
    ref_mem[16'h1234] = 8'h5A;
    m_idx = 16'h1235;
    check("rs_wr_count", q_wr.size(), 32'd1);
    check("rs_idx", 32'(reg_addr), 32'(m_idx));

    // Index wrap.
    wbuf = '{8'h11, 8'h22};
    txn_write(16'hFFFF);

    // Randomized writes and reads against the reference model.
    for (int it = 0; it < 10; it++) begin
      logic [15:0] idx;
      int unsigned len;
      idx = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFE + $urandom_range(0, 3)) : 16'($urandom);
      len = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 0) begin
        wbuf = '{};
        for (int unsigned k = 0; k < len; k++) wbuf.push_back(8'($urandom));
        txn_write(idx);
      end else begin
        txn_read(($urandom_range(0, 2) != 0), idx, len);
      end
    end
    check("strobe_clash", strobe_clash, 32'd0);

    // Reset while the target drives a 0 in RD.
    regs[m_idx] = 8'h00; ref_mem[m_idx] = 8'h00;
    bus_start();
    write_byte(8'h21, a);
    check("rr_dev_ack", 32'(a), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 4 * HALF && !seen; i++) begin
      @(posedge clk_in);
      #1;
      if (sda === 1'b0) seen = 1'b1;
    end
    check("rr_drive_seen", 32'(seen), 32'd1);
    @(negedge clk_in);
    reset = 1'b1;
    @(posedge clk_in);
    #1;
    check("rr_sda_released", 32'(sda === 1'b1), 32'd1);
    check("rr_addr", 32'(reg_addr), 32'd0);
    check("rr_wdata", 32'(reg_wdata), 32'd0);
    check("rr_we_re", 32'({reg_we, reg_re}), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    wait_clk(2);
    reset = 1'b0;
    m_idx = 16'h0000;
    wait_clk(4);
    m_sda_low = 1'b1;
    wait_clk(4);
    m_scl = 1'b1;
    wait_clk(HALF);
    m_sda_low = 1'b0;
    wait_clk(HALF);

    // Target is usable again after reset.
    wbuf = '{8'hC3};
    txn_write(16'h0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cci_target.md
# cci_target

- CCI (I2C with 16-bit register index) target that answers the sensor-control transactions our camera drivers issue.
- Decodes START/STOP, matches the device address, latches a 16-bit register index, then performs auto-incrementing writes and reads over a simple external register port.
- Used as an IMX219 stand-in for closed-loop simulation of the driver, and as an FPGA-side register target on the CCI bus.
- No clock stretching: SCL is input-only; SDA is open-drain.

## Interface
- `ADDRESS`, default 8'h20: 8-bit write address; the target responds to `ADDRESS[7:1]` with either R/W bit.
- `INPUT_CLK_RATE`, default 48000000: clk_in frequency in Hz. Must be at least 20× the SCL rate.
- `clk_in`, input, 1: the only clock.
- `reset`, input, 1: synchronous, active-high.
- `scl`, inout wire, 1: never driven.
- `sda`, inout wire, 1: driven only to 0 (while `sda_oe`), otherwise `'z`.
- `reg_addr`, output, 16: current register index.
- `reg_wdata`, output, 8: write data; valid with `reg_we`.
- `reg_we`, output, 1: one-cycle write strobe.
- `reg_re`, output, 1: one-cycle read request.
- `reg_rdata`, input, 8: read data; sampled exactly 1 cycle after `reg_re`.
- `busy`, output, 1: high from an address match until STOP, or until the next START that does not match.

## Operation
- **Line conditioning:**
  - scl/sda pass through a 2-flop synchronizer.
  - Edges are detected on the synchronized values.
  - START = sda fall while scl high. STOP = sda rise while scl high.
- **Sampling and driving:**
  - Bits are sampled on the synchronized SCL rising edge.
  - SDA is changed 1 cycle after the synchronized SCL falling edge.
- **States:** IDLE, DEV, DEV_ACK, IDX_HI, IDX_HI_ACK, IDX_LO, IDX_LO_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
- **START (including repeated START), from any state:**
  - Release SDA, clear the bit counter, go to DEV.
  - Partial bytes are discarded.
- **STOP, from any state:** release SDA, go to IDLE, `busy` <= 0.
- **DEV:** shift 8 bits MSB-first.
  - Address mismatch → IGNORE; no ACK is driven.
  - Match with R/W=0 → DEV_ACK, then IDX_HI.
  - Match with R/W=1 → DEV_ACK with read prefetch, then RD.
- **IDX_HI, IDX_LO:** each byte is ACKed.
  - `reg_addr` takes the new 16-bit index only after the LO byte is complete.
  - A START or STOP after only the HI byte leaves the index unchanged.
- **WR:** each complete byte produces:
  - `reg_wdata` <= byte and a 1-cycle `reg_we` pulse at the 8th SCL rise.
  - An ACK.
  - `reg_addr` += 1 on the cycle after `reg_we`.
- **Read prefetch:**
  - Triggered at the SCL rise of the DEV_ACK bit, and at the SCL rise of a master ACK in RD_ACK.
  - `reg_re` pulses for 1 cycle; `reg_rdata` is latched into the shift register next cycle.
  - `reg_addr` += 1 after the latch.
- **RD:** drive shift-register bits MSB-first (1 → release SDA, 0 → pull low), then release SDA for RD_ACK.
  - Master ACK (sda=0) → RD with the next byte.
  - Master NACK → IGNORE.
- **Index wrap:** 16'hFFFF + 1 = 16'h0000.
- **Index persistence:** the index holds across STOP. Reset sets it to 0.
- **IGNORE:** SDA released; leaves only on START or STOP.

## Timing
- **Reset values:** `sda` released; `reg_addr`=0, `reg_wdata`=0, `reg_we`=0, `reg_re`=0, `busy`=0; state IDLE.
- **Reset mid-transfer:** SDA is released on the same edge.
- **Bus-event latency:** START/STOP takes effect 3 clk_in cycles after the pin edge (2 sync + 1 detect).
- **ACK drive window:** SDA is pulled low 1 cycle after the detected SCL fall that ends the 8th bit, and released 1 cycle after the next SCL fall.
- **Read-data setup:** `reg_rdata` is needed within 1 cycle of `reg_re`. It reaches SDA at the following SCL fall, at least 7 cycles later given the 20× ratio.
- **Simultaneous events:** if a START or STOP is detected in the same cycle as an SCL edge, the START/STOP wins.
- **Strobes:** `reg_we` and `reg_re` are never asserted in the same cycle.

## Structure
- **Package `cci_pkg`:**
  - `cci_state_t` enum.
  - `CCI_ACK`=1'b0, `CCI_NACK`=1'b1.
  - `cci_dev_addr7()` helper.
- **Sub-module `i2c_line_sync`:**
  - 2-flop synchronizer plus rise/fall detection.
  - Instantiated once per line (scl, sda).

## Test plan
- **Write burst:** START, 0x20, 0x01, 0x00, 0xAA, 0x55, STOP → 3 ACKs on address/index, then `reg_we` with (0x0100, 0xAA) and (0x0101, 0x55); final `reg_addr`=0x0102.
- **Combined read:**
  - Stimulus: write index 0x0000, repeated START, 0x21; model returns 0x02 then 0x19; master ACKs then NACKs.
  - Required: SDA carries 0x02, 0x19; `reg_re` pulses at 0x0000 and 0x0001; state IGNORE until STOP.
- **Address mismatch:** START, 0x30 → SDA never pulled low for the transaction, no strobes, `busy`=0.
- **Aborts:**
  - STOP after the 5th bit of the index HI byte → state IDLE, index unchanged.
  - Repeated START mid-WR byte → no `reg_we`.
- **Index wrap:** write index 0xFFFF, then 2 data bytes → writes land at 0xFFFF, then 0x0000.
- **Reset mid-read:** `reset` asserted while the target drives 0 in RD → SDA released next cycle, all outputs at reset values, index 0.
